// File: rtl/uibi_arbiter_if.sv
// uibi_arbiter_if: master-side request/response and UIBI bus signals of the arbiter
// slave modport is the arbiter's view; master modport is the requesters + bus model view
interface uibi_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int XLEN        = 32,
    parameter int NUM_W       = 4,
    parameter int GNT_W       = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0]       m_req;
    logic [NUM_MASTERS-1:0]       m_wen;
    logic [3*NUM_MASTERS-1:0]     m_mode;
    logic [XLEN*NUM_MASTERS-1:0]  m_addr;
    logic [NUM_W*NUM_MASTERS-1:0] m_num;
    logic [XLEN*NUM_MASTERS-1:0]  m_dat_w;
    logic [XLEN-1:0]              m_dat_r;
    logic [NUM_MASTERS-1:0]       m_ready;
    logic                         m_err;
    logic                         bus_req;
    logic                         bus_wen;
    logic [2:0]                   bus_mode;
    logic [XLEN-1:0]              bus_addr;
    logic [NUM_W-1:0]             bus_num;
    logic [XLEN-1:0]              bus_dat_o;
    logic [XLEN-1:0]              bus_dat_i;
    logic                         bus_ready;
    logic [GNT_W-1:0]             gnt_idx;
    modport slave (
        input  m_req, m_wen, m_mode, m_addr, m_num, m_dat_w, bus_dat_i, bus_ready,
        output m_dat_r, m_ready, m_err, bus_req, bus_wen, bus_mode, bus_addr, bus_num,
               bus_dat_o, gnt_idx
    );
    modport master (
        output m_req, m_wen, m_mode, m_addr, m_num, m_dat_w, bus_dat_i, bus_ready,
        input  m_dat_r, m_ready, m_err, bus_req, bus_wen, bus_mode, bus_addr, bus_num,
               bus_dat_o, gnt_idx
    );
endinterface

// File: rtl/uibi_arbiter.sv
// uibi_arbiter: round-robin N-master to single UIBI bus arbiter with per-transaction timeout
// Ports: clk; rst (synchronous, active-low); u (slave side: m_* requests/responses, bus_* UIBI port, gnt_idx)
module uibi_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int XLEN        = 32,
    parameter int NUM_W       = 4,
    parameter int TIMEOUT     = 256,
    parameter int GNT_W       = $clog2(NUM_MASTERS)
) (
    input logic          clk,
    input logic          rst,
    uibi_arbiter_if.slave u
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    state_t state, state_n;
    logic [GNT_W-1:0] last, pick, j;
    logic [CW-1:0] cnt;
    logic tmo;
    always_ff @(posedge clk)
        state <= !rst ? IDLE : state_n;
    // descending scan so the requester nearest after last wins
    always_comb begin
        pick = '0;
        j = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            j = GNT_W'((int'(last) + k) % NUM_MASTERS);
            if (u.m_req[j]) pick = j;
        end
        tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
        state_n = state == IDLE ? (|u.m_req ? BUSY : IDLE) :
                  state == BUSY ? (u.bus_ready || tmo ? RESP : BUSY) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            u.bus_req   <= 1'b0;
            u.bus_wen   <= 1'b0;
            u.bus_mode  <= '0;
            u.bus_addr  <= '0;
            u.bus_num   <= '0;
            u.bus_dat_o <= '0;
            u.m_ready   <= '0;
            u.m_err     <= 1'b0;
            u.m_dat_r   <= '0;
            u.gnt_idx   <= '0;
            last        <= GNT_W'(NUM_MASTERS - 1);
            cnt         <= '0;
        end else begin
            u.m_ready <= '0;
            u.m_err   <= 1'b0;
            if (state == IDLE && |u.m_req) begin
                u.gnt_idx   <= pick;
                last        <= pick;
                u.bus_wen   <= u.m_wen[pick];
                u.bus_mode  <= u.m_mode[pick*3 +: 3];
                u.bus_addr  <= u.m_addr[pick*XLEN +: XLEN];
                u.bus_num   <= u.m_num[pick*NUM_W +: NUM_W];
                u.bus_dat_o <= u.m_dat_w[pick*XLEN +: XLEN];
                u.bus_req   <= 1'b1;
                cnt         <= '0;
            end
            // bus_ready takes precedence over a coincident timeout
            if (state == BUSY) begin
                if (u.bus_ready || tmo) begin
                    u.bus_req <= 1'b0;
                    u.m_ready <= NUM_MASTERS'(1) << u.gnt_idx;
                    u.m_err   <= !u.bus_ready;
                    u.m_dat_r <= u.bus_ready ? u.bus_dat_i : '0;
                end else if (TIMEOUT != 0) begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_uibi_arbiter.sv
// tb_uibi_arbiter: directed stimulus with scoreboard-checked responses for uibi_arbiter
module tb_uibi_arbiter;
    localparam int N = 4, X = 32, W = 4, T = 8;
    typedef struct {
        logic [N-1:0] rdy;
        logic         err;
        logic [X-1:0] dat;
        logic [1:0]   gnt;
        logic [X-1:0] addr;
        logic [W-1:0] num;
        logic         wen;
        logic [2:0]   mode;
        logic [X-1:0] dw;
        int           cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int vecs = 0, fails = 0, cyc = 0;
    exp_t sbq[$];
    exp_t me;
    logic [X-1:0] a[N];
    logic [X-1:0] dw[N];
    logic [W-1:0] nm[N];
    logic [N-1:0] wn;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    uibi_arbiter_if #(.NUM_MASTERS(N), .XLEN(X), .NUM_W(W)) u();
    uibi_arbiter #(.NUM_MASTERS(N), .XLEN(X), .NUM_W(W), .TIMEOUT(T)) dut (
        .clk(clk),
        .rst(rst),
        .u(u)
    );
    task automatic chk(input string name, input logic [X-1:0] got, input logic [X-1:0] exp);
        vecs++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            u.m_addr[i*X +: X]  = a[i];
            u.m_num[i*W +: W]   = nm[i];
            u.m_dat_w[i*X +: X] = dw[i];
            u.m_mode[i*3 +: 3]  = 3'(i);
        end
        u.m_wen = wn;
    endtask
    // called on an IDLE negedge; returns on the IDLE negedge after RESP
    task automatic xact(input logic [N-1:0] req, input int g, input int lat,
                        input logic [X-1:0] rd, input bit chg);
        exp_t e;
        int stop;
        stop   = (lat != 0) ? lat : T;
        e.rdy  = 4'(1) << g;
        e.err  = (lat == 0);
        e.dat  = (lat != 0) ? rd : '0;
        e.gnt  = 2'(g);
        e.addr = a[g];
        e.num  = nm[g];
        e.wen  = wn[g];
        e.mode = 3'(g);
        e.dw   = dw[g];
        e.cyc  = cyc + stop + 1;
        sbq.push_back(e);
        u.m_req = req;
        for (int n = 1; n <= stop; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("bus_req_busy", 32'(u.bus_req), 32'd1);
                if (chg) begin
                    a[g] = 32'h40;
                    drive();
                end
            end
            u.bus_ready = (n == lat);
            u.bus_dat_i = rd;
        end
        @(negedge clk);
        u.bus_ready = 1'b0;
        u.m_req = req & ~e.rdy;
        @(negedge clk);
    endtask
    always @(negedge clk) begin
        if (|u.m_ready || u.m_err) begin
            if (sbq.size() == 0) begin
                vecs++;
                fails++;
                $display("FAIL spurious_ready got=%b exp=0000", u.m_ready);
            end else begin
                me = sbq.pop_front();
                chk("m_ready",   32'(u.m_ready),   32'(me.rdy));
                chk("m_err",     32'(u.m_err),     32'(me.err));
                chk("m_dat_r",   u.m_dat_r,        me.dat);
                chk("gnt_idx",   32'(u.gnt_idx),   32'(me.gnt));
                chk("bus_addr",  u.bus_addr,       me.addr);
                chk("bus_num",   32'(u.bus_num),   32'(me.num));
                chk("bus_wen",   32'(u.bus_wen),   32'(me.wen));
                chk("bus_mode",  32'(u.bus_mode),  32'(me.mode));
                chk("bus_dat_o", u.bus_dat_o,      me.dw);
                chk("bus_req_resp", 32'(u.bus_req), 32'd0);
                chk("resp_cycle", 32'(cyc),        32'(me.cyc));
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
    initial begin
        a  = '{32'h1000, 32'h20, 32'h2000, 32'h3000};
        nm = '{4'd2, 4'd3, 4'd4, 4'd5};
        dw = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        wn = 4'b0100;
        u.m_req = '0;
        u.bus_ready = 1'b0;
        u.bus_dat_i = '0;
        drive();
        repeat (3) @(negedge clk);
        chk("rst_bus_req",  32'(u.bus_req),  32'd0);
        chk("rst_bus_addr", u.bus_addr,      32'd0);
        chk("rst_m_ready",  32'(u.m_ready),  32'd0);
        chk("rst_m_err",    32'(u.m_err),    32'd0);
        chk("rst_m_dat_r",  u.m_dat_r,       32'd0);
        chk("rst_gnt_idx",  32'(u.gnt_idx),  32'd0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) xact(4'b1111, i % N, 1, 32'h100 + i, 1'b0);
        xact(4'b0001, 0, 3, 32'hDEADBEEF, 1'b0);
        xact(4'b0010, 1, 2, 32'h11112222, 1'b1);
        xact(4'b1000, 3, 0, 32'h55555555, 1'b0);
        xact(4'b0100, 2, T, 32'hCAFEF00D, 1'b0);
        xact(4'b1001, 3, 1, 32'h77, 1'b0);
        xact(4'b1001, 0, 1, 32'h88, 1'b0);
        xact(4'b0011, 1, 1, 32'h99, 1'b0);
        u.m_req = 4'b0100;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_bus_req", 32'(u.bus_req), 32'd0);
        chk("midrst_gnt_idx", 32'(u.gnt_idx), 32'd0);
        rst = 1'b1;
        u.m_req = '0;
        u.bus_ready = 1'b1;
        u.bus_dat_i = 32'hBAD0BAD0;
        @(negedge clk);
        chk("late_ready_bus_req", 32'(u.bus_req), 32'd0);
        chk("late_ready_m_ready", 32'(u.m_ready), 32'd0);
        u.bus_ready = 1'b0;
        xact(4'b1111, 0, 1, 32'hA5A5A5A5, 1'b0);
        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule

// File: doc/uibi_arbiter.md
Name: uibi_arbiter

Overview:
Parametrised N-master to 1-bus UIBI arbiter. It lets several core+mmu pairs share the single UIBI master port of a multi-core cluster. Arbitration is round-robin, and each winning master's request is latched for the duration of its transaction. A per-transaction timeout returns an error response if the bus never answers.

Parameters:
NUM_MASTERS, 2, number of requesting masters (≥2)
XLEN, 32, address/data width
NUM_W, 4, width of bus_num (target device select)
TIMEOUT, 256, cycles in BUSY before an error response is returned; 0 disables the timeout
GNT_W, $clog2(NUM_MASTERS), width of the grant index

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
m_req  in  NUM_MASTERS  per-master request; held high until that master's m_ready
m_wen  in  NUM_MASTERS  per-master write enable
m_mode  in  3*NUM_MASTERS  per-master access mode (width/sign), slice i = [3i+2:3i]
m_addr  in  XLEN*NUM_MASTERS  per-master address
m_num  in  NUM_W*NUM_MASTERS  per-master target device number
m_dat_w  in  XLEN*NUM_MASTERS  per-master write data
m_dat_r  out  XLEN  read data, shared by all masters; valid when m_ready[i]=1
m_ready  out  NUM_MASTERS  one-hot completion pulse
m_err  out  1  qualifies m_ready: 1 = timeout, no bus response
bus_req  out  1  UIBI request
bus_wen  out  1  UIBI write enable
bus_mode  out  3  UIBI mode
bus_addr  out  XLEN  UIBI address
bus_num  out  NUM_W  UIBI device number
bus_dat_o  out  XLEN  UIBI write data
bus_dat_i  in  XLEN  UIBI read data
bus_ready  in  1  UIBI completion, sampled only in BUSY
gnt_idx  out  GNT_W  index of the current or last granted master (debug/perf)

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; all bus_* outputs 0; m_ready=0; m_err=0; m_dat_r=0; gnt_idx=0.
  - Round-robin pointer last=NUM_MASTERS-1, so master 0 has top priority first.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any m_req is set, pick the first requester scanning last+1, last+2, … (mod NUM_MASTERS).
  - Register gnt_idx and last at that index.
  - Latch the winner's wen/mode/addr/num/dat_w into the bus_* registers, clear the timeout counter, set bus_req=1, go to BUSY.
  - If no m_req is set, stay in IDLE with bus_req=0.
- BUSY:
  - bus_* outputs are held stable from the latches; master inputs are ignored; other masters' requests wait.
  - On bus_ready=1: m_dat_r<=bus_dat_i (reads; writes load bus_dat_i as well, and its value is don't-care); bus_req<=0; m_ready<=onehot(gnt_idx); m_err<=0; go to RESP.
  - Else, if TIMEOUT≠0 and counter==TIMEOUT-1: bus_req<=0; m_dat_r<=0; m_ready<=onehot(gnt_idx); m_err<=1; go to RESP.
  - Else the counter increments. Counter width is $clog2(TIMEOUT+1), and it never wraps.
  - bus_ready and timeout in the same cycle: bus_ready wins, m_err=0.
- RESP:
  - m_ready and m_err are high for exactly this one cycle.
  - Next state is IDLE; m_ready and m_err return to 0.
  - The granted master must drop m_req in the cycle after RESP; IDLE does not re-grant it unless it raises m_req again.
  - bus_ready seen in IDLE or RESP is ignored.
- Latency:
  - m_req seen at cycle 0 → bus_req=1 from cycle 1.
  - bus_ready at cycle k → m_ready at cycle k+1 → IDLE at k+2.
  - Earliest next grant is at cycle k+2, visible on the bus at k+3.
- Fairness: any continuously requesting master is granted within NUM_MASTERS transactions.
- Reset mid-transaction: the transaction is abandoned and no m_ready is issued.
  - bus_req drops on the reset edge; any late bus_ready is ignored in IDLE.
- m_dat_r holds its value until the next completion.

Test Plan:
- Single read: m_req[0]=1, addr=0x1000, num=2; bus_ready at 3rd BUSY cycle with bus_dat_i=0xDEADBEEF → bus_addr=0x1000, bus_num=2; m_ready=0b01 for one cycle; m_dat_r=0xDEADBEEF; m_err=0.
- Round-robin: NUM_MASTERS=4, all m_req held, bus_ready 1 cycle after each grant → gnt_idx sequence 0,1,2,3,0; no master is granted twice before every other master is granted once.
- Stability: master 1 changes m_addr from 0x20 to 0x40 while in BUSY → bus_addr stays 0x20 until RESP.
- Timeout: TIMEOUT=8, bus_ready never asserted → after exactly 8 BUSY cycles m_ready[g]=1, m_err=1, m_dat_r=0, bus_req=0.
- bus_ready and timeout coincide on cycle TIMEOUT-1 → m_err=0 and data is taken from bus_dat_i.
- Reset in BUSY: assert rst=0 one cycle, then drive bus_ready=1 → no m_ready pulse; state is IDLE; master 0 is granted first on the next requests.
